mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Bus-side responder for the CPU's byte-wide memory port: it serves RAM reads and writes and decodes the memory-mapped I/O window at 0x30000. It holds 128 KB of byte RAM, a UART transmit FIFO that drives `io_buffer_full`, a one-byte UART receive holding register, a free-running cycle counter and the program-stop latch. It sits between the CPU top and the UART/host interface, on the far side of the `mem_a`/`mem_dout`/`mem_din`/`mem_wr` bus.

## Interface
- `RAM_ADDR_WIDTH`, 17: RAM byte-address bits; depth is 2^17 bytes.
- `TX_DEPTH_LOG`, 3: log2 of TX FIFO depth (8 entries).
- `TX_FULL_MARGIN`, 2: `io_buffer_full` asserts when free entries ≤ this value.
- Clock and reset: one clock (`clk_in`); reset is asynchronous and active-low (`rst_n_in`).
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: async active-low reset.
- `bus_a` in 32: CPU address; only [17:0] decoded.
- `bus_wr` in 1: 1 = write, 0 = read.
- `bus_wdata` in 8: CPU write byte (CPU `mem_dout`).
- `bus_rdata` out 8: read byte to CPU (CPU `mem_din`).
- `io_buffer_full` out 1: TX FIFO near-full backpressure to CPU.
- `uart_tx_valid` out 1, `uart_tx_data` out 8, `uart_tx_ready` in 1: TX drain handshake.
- `uart_rx_valid` in 1, `uart_rx_data` in 8, `uart_rx_ready` out 1: RX fill handshake.
- `program_stop` out 1: sticky; a write to 0x30004 has occurred.
- `stop_done` out 1: `program_stop` is set and the TX FIFO is empty.
- `tx_overflow` out 1: sticky; a push was attempted while the FIFO was full.

## Operation
- Decode: `bus_a[17:16]==2'b11` selects I/O. Otherwise the access goes to RAM if `bus_a[17] == 0`. Addresses 0x20000–0x2FFFF read 0 and ignore writes.
- RAM write: byte written at the clock edge. RAM read: registered.
- I/O write 0x30000: push `bus_wdata` to the TX FIFO. A value of 0x00 is ignored.
- I/O write 0x30004: set `program_stop` and push 0x00 to the TX FIFO.
- I/O read 0x30000:
  - If the RX holding register is valid, return its byte and clear valid.
  - Otherwise return 0x00.
- I/O read 0x30004–0x30007: return counter bytes 0–3, little-endian.
  - A read of 0x30004 returns the live counter byte 0 and latches a 32-bit snapshot.
  - Reads of 0x30005–0x30007 return bytes of that snapshot.
- Other I/O offsets read 0x00; writes to them are ignored.
- Once `program_stop` is set, all further bus writes (RAM and I/O) are ignored. Reads still work and the FIFO keeps draining.
- TX FIFO:
  - Circular buffer with an explicit count of width `TX_DEPTH_LOG`+1.
  - `uart_tx_valid` = count≠0; `uart_tx_data` = head entry.
  - A pop occurs on valid&&ready.
  - A push while count==depth is dropped and sets `tx_overflow`.
  - Simultaneous push and pop at count==depth is accepted; count is unchanged.
- RX: `uart_rx_ready` = !rx_valid. The register loads on valid&&ready.
- Counter: 32-bit, +1 every cycle from reset, wraps 0xFFFFFFFF→0.

## Timing
- Reset values:
  - `bus_rdata`=0, `uart_tx_valid`=0, `uart_tx_data`=0, `uart_rx_ready`=1.
  - `io_buffer_full`=0, `program_stop`=0, `stop_done`=0, `tx_overflow`=0.
  - FIFO empty, counter=0, snapshot=0, rx_valid=0.
- RAM contents are not reset.
- Read latency is 1 cycle: address presented in cycle N, data on `bus_rdata` in N+1. `bus_rdata` holds its value until the next read.
- `io_buffer_full` is registered. It reflects count after the edge's push/pop: asserted when depth−count ≤ `TX_FULL_MARGIN`. This margin absorbs the CPU's in-flight writes.
- An RX pop by a bus read and an RX load in the same cycle cannot coincide, because ready is low while valid is set. A new byte can load one cycle after the read.
- `stop_done` is registered. It rises the cycle after the 0x00 stop byte is popped.
- Reset assertion mid-operation clears all state immediately (asynchronous). Any pending read data is lost.

## Structure
- Shared package: I/O address constants (0x30000, 0x30004), the I/O select pattern `2'b11`, and the RAM size constant.
- One sub-module: `tx_fifo` (parameterised circular byte FIFO with count, push/pop, full/empty/free outputs). The RAM is an inferred array in the top.

## Test plan
- RAM round-trip: write 0xA5 to 0x00123, read 0x00123 → `bus_rdata`=0xA5 exactly one cycle later. Read 0x20010 → 0x00.
- TX path: write 0x41, 0x00, 0x42 to 0x30000 with `uart_tx_ready`=1 → 0x41 then 0x42 are emitted; the 0x00 is never pushed.
- Backpressure: hold `uart_tx_ready`=0 and write 6 bytes → `io_buffer_full`=1 after the 6th write. Writes 7–8 are accepted; a 9th write sets `tx_overflow` and the FIFO still holds the first 8.
- Counter: read 0x30004 at counter 0x000001FF, then read 0x30005 two cycles later → bytes 0xFF and 0x01 from the same snapshot.
- RX: drive `uart_rx_data`=0x33 with valid → `uart_rx_ready` falls. Read 0x30000 → 0x33, and `uart_rx_ready`=1 next cycle. A second read → 0x00.
- Stop: write 0x30004 with 3 bytes queued → `program_stop`=1. A later RAM write is ignored. `stop_done` rises after the final 0x00 drains. Asserting `rst_n_in` mid-drain clears all outputs at once.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the CPU memory-port responder:
// I/O window addresses, I/O select pattern and RAM size.
package mem_io_responder_pkg;

    localparam int          RAM_AW      = 17;
    localparam int          RAM_BYTES   = 1 << RAM_AW;
    localparam logic [1:0]  IO_SEL      = 2'b11;
    localparam logic [17:0] IO_TX_ADDR  = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR = 18'h30004;

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// Circular byte FIFO with an explicit occupancy count;
// pushes at full are dropped unless a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH_LOG = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_LOG:0] free
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

    logic [7:0]           mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [CW-1:0]        count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == DEPTH_V);
    assign empty   = (count == '0);
    assign free    = DEPTH_V - count;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory-port responder: 128 KB RAM, UART TX FIFO,
// RX holding register, cycle counter and program-stop latch.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = RAM_AW,
    parameter int TX_DEPTH_LOG   = 3,
    parameter int TX_FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_ready,
    output logic        program_stop,
    output logic        stop_done,
    output logic        tx_overflow
);

    localparam int FW = TX_DEPTH_LOG + 1;
    localparam logic [FW-1:0] DEPTH_V  = FW'(1 << TX_DEPTH_LOG);
    localparam logic [FW-1:0] MARGIN_V = FW'(TX_FULL_MARGIN);

    logic [7:0]  ram [2**RAM_ADDR_WIDTH];
    logic [17:0] addr;
    logic        unused_hi;
    logic        ram_sel;
    logic        wr_en;
    logic [7:0]  rd_next;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] counter;
    logic [31:0] snapshot;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_drop;
    logic        tx_acc;
    logic        tx_full;
    logic        tx_empty;
    logic [FW-1:0] tx_free;
    logic [FW-1:0] free_next;
    logic [7:0]  tx_wdata;
    logic        stop_set;
    logic        rx_pop;

    assign addr      = bus_a[17:0];
    assign unused_hi = ^bus_a[31:18];
    assign ram_sel   = !addr[17];
    assign wr_en     = bus_wr && !program_stop;
    assign stop_set  = wr_en && (addr == IO_CNT_ADDR);
    assign tx_push   = stop_set ||
                       (wr_en && addr == IO_TX_ADDR && bus_wdata != 8'h00);
    assign tx_wdata  = stop_set ? 8'h00 : bus_wdata;
    assign tx_pop    = uart_tx_valid && uart_tx_ready;
    assign tx_drop   = tx_push && tx_full && !tx_pop;
    assign tx_acc    = tx_push && !tx_drop;
    assign free_next = tx_free - FW'(tx_acc) + FW'(tx_pop);
    assign rx_pop    = !bus_wr && (addr == IO_TX_ADDR) && rx_valid;

    assign uart_tx_valid = !tx_empty;
    assign uart_rx_ready = !rx_valid;

    tx_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_wdata),
        .rdata (uart_tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .free  (tx_free)
    );

    always_ff @(posedge clk_in) begin
        if (wr_en && ram_sel) ram[addr[RAM_ADDR_WIDTH-1:0]] <= bus_wdata;
    end

    always_comb begin
        rd_next = 8'h00;
        if (ram_sel) begin
            rd_next = ram[addr[RAM_ADDR_WIDTH-1:0]];
        end else if (addr[17:16] == IO_SEL) begin
            case (addr)
                IO_TX_ADDR:          rd_next = rx_valid ? rx_data : 8'h00;
                IO_CNT_ADDR:         rd_next = counter[7:0];
                IO_CNT_ADDR + 18'd1: rd_next = snapshot[15:8];
                IO_CNT_ADDR + 18'd2: rd_next = snapshot[23:16];
                IO_CNT_ADDR + 18'd3: rd_next = snapshot[31:24];
                default:             rd_next = 8'h00;
            endcase
        end
    end

    // stop_done and io_buffer_full look at the FIFO state after this edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus_rdata      <= '0;
            rx_valid       <= 1'b0;
            rx_data        <= '0;
            counter        <= '0;
            snapshot       <= '0;
            program_stop   <= 1'b0;
            stop_done      <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (!bus_wr) bus_rdata <= rd_next;
            if (!bus_wr && addr == IO_CNT_ADDR) snapshot <= counter;
            if (uart_rx_valid && !rx_valid) begin
                rx_valid <= 1'b1;
                rx_data  <= uart_rx_data;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (stop_set) program_stop <= 1'b1;
            if (tx_drop) tx_overflow <= 1'b1;
            io_buffer_full <= (free_next <= MARGIN_V);
            stop_done <= (program_stop || stop_set) &&
                         (free_next == DEPTH_V);
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed, table-driven bench for mem_io_responder with
// hand-written sequences for TX, RX, counter and stop behaviour.
module tb_mem_io_responder;

    localparam logic [31:0] IDLE = 32'h0002FFF0;

    logic        clk;
    logic        rst_n;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic        program_stop;
    logic        stop_done;
    logic        tx_overflow;

    int nvec = 0;
    int nerr = 0;
    logic [7:0]  txq[$];
    logic [31:0] mcnt;

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[17];

    mem_io_responder dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .bus_a          (bus_a),
        .bus_wr         (bus_wr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .io_buffer_full (io_buffer_full),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_ready  (uart_tx_ready),
        .uart_rx_valid  (uart_rx_valid),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_ready  (uart_rx_ready),
        .program_stop   (program_stop),
        .stop_done      (stop_done),
        .tx_overflow    (tx_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference cycle counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 32'd0;
        else mcnt <= mcnt + 32'd1;
    end

    always @(negedge clk) begin
        if (rst_n && uart_tx_valid && uart_tx_ready)
            txq.push_back(uart_tx_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_bus(input logic [31:0] a, input logic [7:0] d);
        bus_wr    = 1'b1;
        bus_a     = a;
        bus_wdata = d;
        step();
        bus_wr = 1'b0;
        bus_a  = IDLE;
    endtask

    task automatic rd_bus(input logic [31:0] a);
        bus_wr = 1'b0;
        bus_a  = a;
        step();
        bus_a = IDLE;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdata"}, {24'd0, bus_rdata}, 32'h00);
        chk({tag, "_txv"}, {31'd0, uart_tx_valid}, 32'd0);
        chk({tag, "_txd"}, {24'd0, uart_tx_data}, 32'h00);
        chk({tag, "_rxr"}, {31'd0, uart_rx_ready}, 32'd1);
        chk({tag, "_full"}, {31'd0, io_buffer_full}, 32'd0);
        chk({tag, "_stop"}, {31'd0, program_stop}, 32'd0);
        chk({tag, "_done"}, {31'd0, stop_done}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, tx_overflow}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h00000123, 8'hA5, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 32'h00000123, 8'h00, 1'b1, 8'hA5};
        tbl[2]  = '{1'b1, 32'h0000FFFF, 8'h11, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 32'h0001FFFF, 8'h5A, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 32'h0002FFFF, 8'h77, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 32'h0000FFFF, 8'h00, 1'b1, 8'h11};
        tbl[6]  = '{1'b0, 32'h0001FFFF, 8'h00, 1'b1, 8'h5A};
        tbl[7]  = '{1'b0, 32'h0002FFFF, 8'h00, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, 32'h00020010, 8'h00, 1'b1, 8'h00};
        tbl[9]  = '{1'b1, 32'h00020010, 8'h99, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 32'h00020010, 8'h00, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 32'hFFFC0123, 8'h00, 1'b1, 8'hA5};
        tbl[12] = '{1'b0, 32'h00030008, 8'h00, 1'b1, 8'h00};
        tbl[13] = '{1'b1, 32'h00000000, 8'h3C, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 32'h00030001, 8'h00, 1'b1, 8'h00};
        tbl[15] = '{1'b0, 32'h00000000, 8'h00, 1'b1, 8'h3C};
        tbl[16] = '{1'b1, 32'h00000001, 8'hC3, 1'b1, 8'h3C};

        rst_n = 1'b0;
        bus_a = IDLE;
        bus_wr = 1'b0;
        bus_wdata = 8'h00;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'h00;
        #1;
        chk_reset("rst0");
        step();
        step();
        rst_n = 1'b1;
        step();

        // RAM / decode table
        for (int i = 0; i < 17; i++) begin
            bus_wr    = tbl[i].wr;
            bus_a     = tbl[i].a;
            bus_wdata = tbl[i].d;
            step();
            if (tbl[i].chk)
                chk($sformatf("vec%0d", i), {24'd0, bus_rdata},
                    {24'd0, tbl[i].exp});
        end
        bus_wr = 1'b0;
        bus_a  = IDLE;
        step();

        // TX path, zero byte dropped
        uart_tx_ready = 1'b1;
        txq.delete();
        wr_bus(32'h30000, 8'h41);
        wr_bus(32'h30000, 8'h00);
        wr_bus(32'h30000, 8'h42);
        repeat (4) step();
        chk("tx_len", txq.size(), 2);
        if (txq.size() >= 2) begin
            chk("tx_b0", {24'd0, txq[0]}, 32'h41);
            chk("tx_b1", {24'd0, txq[1]}, 32'h42);
        end
        chk("tx_empty", {31'd0, uart_tx_valid}, 32'd0);

        // backpressure and overflow
        uart_tx_ready = 1'b0;
        txq.delete();
        for (int i = 0; i < 9; i++) begin
            wr_bus(32'h30000, 8'h61 + 8'(i));
            if (i == 4) chk("full_at5", {31'd0, io_buffer_full}, 32'd0);
            if (i == 5) chk("full_at6", {31'd0, io_buffer_full}, 32'd1);
            if (i == 7) chk("ovf_at8", {31'd0, tx_overflow}, 32'd0);
            if (i == 8) chk("ovf_at9", {31'd0, tx_overflow}, 32'd1);
        end
        uart_tx_ready = 1'b1;
        repeat (12) step();
        chk("bp_len", txq.size(), 8);
        for (int k = 0; k < 8 && k < txq.size(); k++)
            chk($sformatf("bp_b%0d", k), {24'd0, txq[k]},
                32'h61 + k);
        chk("bp_full_clr", {31'd0, io_buffer_full}, 32'd0);

        // counter snapshot
        for (int k = 0; k < 1000 && mcnt != 32'h1FF; k++) step();
        if (mcnt != 32'h1FF) begin
            nerr++;
            $display("FAIL cnt_wait: act=0x%0h req=0x1ff", mcnt);
        end
        rd_bus(32'h30004);
        chk("cnt_b0", {24'd0, bus_rdata}, 32'hFF);
        step();
        rd_bus(32'h30005);
        chk("cnt_b1", {24'd0, bus_rdata}, 32'h01);
        rd_bus(32'h30006);
        chk("cnt_b2", {24'd0, bus_rdata}, 32'h00);
        rd_bus(32'h30007);
        chk("cnt_b3", {24'd0, bus_rdata}, 32'h00);
        rd_bus(32'h30004);
        chk("cnt2_b0", {24'd0, bus_rdata}, 32'h04);
        rd_bus(32'h30005);
        chk("cnt2_b1", {24'd0, bus_rdata}, 32'h02);

        // RX holding register
        chk("rx_rdy0", {31'd0, uart_rx_ready}, 32'd1);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h33;
        step();
        chk("rx_rdy_lo", {31'd0, uart_rx_ready}, 32'd0);
        uart_rx_valid = 1'b0;
        rd_bus(32'h30000);
        chk("rx_data", {24'd0, bus_rdata}, 32'h33);
        chk("rx_rdy_hi", {31'd0, uart_rx_ready}, 32'd1);
        rd_bus(32'h30000);
        chk("rx_again", {24'd0, bus_rdata}, 32'h00);

        // stop with queued bytes, full drain
        uart_tx_ready = 1'b0;
        txq.delete();
        wr_bus(32'h00050, 8'h12);
        wr_bus(32'h30000, 8'h71);
        wr_bus(32'h30000, 8'h72);
        wr_bus(32'h30000, 8'h73);
        wr_bus(32'h30004, 8'hAA);
        chk("stop_set", {31'd0, program_stop}, 32'd1);
        chk("done_early", {31'd0, stop_done}, 32'd0);
        wr_bus(32'h00050, 8'hEE);
        wr_bus(32'h30000, 8'h74);
        rd_bus(32'h00050);
        chk("stop_ramwr", {24'd0, bus_rdata}, 32'h12);
        uart_tx_ready = 1'b1;
        for (int k = 0; k < 20 && !stop_done; k++) step();
        chk("stop_done", {31'd0, stop_done}, 32'd1);
        chk("stop_len", txq.size(), 4);
        if (txq.size() >= 4) begin
            chk("stop_b0", {24'd0, txq[0]}, 32'h71);
            chk("stop_b1", {24'd0, txq[1]}, 32'h72);
            chk("stop_b2", {24'd0, txq[2]}, 32'h73);
            chk("stop_b3", {24'd0, txq[3]}, 32'h00);
        end
        chk("ovf_sticky", {31'd0, tx_overflow}, 32'd1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // reset asserted mid-drain
        uart_tx_ready = 1'b0;
        wr_bus(32'h30000, 8'h81);
        wr_bus(32'h30000, 8'h82);
        wr_bus(32'h30004, 8'h00);
        uart_tx_ready = 1'b1;
        bus_a = 32'h00123;
        step();
        bus_a = IDLE;
        chk("mid_rdata", {24'd0, bus_rdata}, 32'hA5);
        chk("mid_txv", {31'd0, uart_tx_valid}, 32'd1);
        chk("mid_stop", {31'd0, program_stop}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
